// File: rtl/bubble_sort_pkg.sv
// Shared types and helpers for the streaming descending sorter.
// Imported by the sorter top, its interface users and the bench.
package bubble_sort_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SORT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int unsigned DEF_N = 5;
   localparam int unsigned IDX_W = (DEF_N > 1) ? $clog2(DEF_N) : 1;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned worst_cycles(input int unsigned n);
      return n * (n - 1);
   endfunction

endpackage

// File: rtl/bubble_sort_stream_if.sv
// Valid/ready write and read ends of the sorter.
// The master side fills the array and drains the sorted words.
interface bubble_sort_stream_if #(
   parameter int W = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/bubble_sort_stream_cmp_swap.sv
// Compare/swap cell: larger word goes to hi, smaller to lo.
// Equal words keep their order, so swap stays low for ties.
module sort_cmp_swap #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo,
   output logic         swap
);
   assign swap = (a < b);
   assign hi   = swap ? b : a;
   assign lo   = swap ? a : b;
endmodule

// File: rtl/bubble_sort_stream.sv
// Streaming wrapper: load N words, bubble-sort descending in place,
// then stream them out largest first with out_last on the smallest.
module bubble_sort_stream
   import bubble_sort_pkg::*;
#(
   parameter int N  = 5,
   parameter int W  = 8,
   parameter int CW = 8
) (
   input  logic                clk,
   input  logic                rst,
   bubble_sort_stream_if.slave bus,
   output logic                busy,
   output logic [CW-1:0]       sort_cycles
);
   localparam int IW = idx_width(N);
   typedef logic [IW-1:0] idx_t;
   localparam idx_t LAST = idx_t'(N - 1);
   localparam idx_t PEND = idx_t'(N - 2);

   state_t       state, state_nx;
   logic [W-1:0] r [N];
   idx_t         wr_idx, rd_idx, p, p1;
   logic         swapped;
   logic [W-1:0] a, b, hi, lo;
   logic         swp;
   logic         in_fire, out_fire;

   assign p1 = p + idx_t'(1);
   assign a  = r[p];
   assign b  = r[p1];

   sort_cmp_swap #(.W(W)) u_cmp (
      .a    (a),
      .b    (b),
      .hi   (hi),
      .lo   (lo),
      .swap (swp)
   );

   assign bus.in_ready  = (state == LOAD);
   assign bus.out_valid = (state == DRAIN);
   assign bus.out_data  = (state == DRAIN) ? r[rd_idx] : '0;
   assign bus.out_last  = (state == DRAIN) && (rd_idx == LAST);
   assign busy          = (state != LOAD);

   assign in_fire  = bus.in_valid && bus.in_ready;
   assign out_fire = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         LOAD:
            if (in_fire && wr_idx == LAST)
               state_nx = SORT;
         SORT:
            // a pass with no swap at all means the array is ordered
            if (p == PEND && !(swapped || swp))
               state_nx = DRAIN;
         DRAIN:
            if (out_fire && rd_idx == LAST)
               state_nx = LOAD;
         default:
            state_nx = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) r[i] <= '0;
         wr_idx      <= '0;
         rd_idx      <= '0;
         p           <= '0;
         swapped     <= 1'b0;
         sort_cycles <= '0;
      end else begin
         unique case (state)
            LOAD: begin
               if (in_fire) begin
                  r[wr_idx] <= bus.in_data;
                  if (wr_idx == LAST) begin
                     wr_idx      <= '0;
                     p           <= '0;
                     swapped     <= 1'b0;
                     sort_cycles <= '0;
                  end else begin
                     wr_idx <= wr_idx + idx_t'(1);
                  end
               end
            end
            SORT: begin
               r[p]        <= hi;
               r[p1]       <= lo;
               sort_cycles <= sort_cycles + CW'(1);
               if (p == PEND) begin
                  p       <= '0;
                  swapped <= 1'b0;
               end else begin
                  p       <= p + idx_t'(1);
                  swapped <= swapped | swp;
               end
            end
            DRAIN: begin
               if (out_fire) begin
                  if (rd_idx == LAST) rd_idx <= '0;
                  else                rd_idx <= rd_idx + idx_t'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_bubble_sort_stream.sv
// Randomized bench for bubble_sort_stream against a reference
// built from descending order and inversion counts.
module tb_bubble_sort_stream;
   import bubble_sort_pkg::*;

   localparam int N  = 5;
   localparam int W  = 8;
   localparam int CW = 8;

   typedef logic [W-1:0] batch_t [N];

   logic          clk = 1'b0;
   logic          rst;
   logic          busy;
   logic [CW-1:0] sort_cycles;

   bubble_sort_stream_if #(.W(W)) bus ();

   bubble_sort_stream #(.N(N), .W(W), .CW(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .busy        (busy),
      .sort_cycles (sort_cycles)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // passes = 1 + largest count of smaller words ahead of any word
   function automatic int model_cycles(input batch_t v);
      int m = 0;
      for (int i = 0; i < N; i++) begin
         int c = 0;
         for (int j = 0; j < i; j++)
            if (v[j] < v[i]) c++;
         if (c > m) m = c;
      end
      return (m + 1) * (N - 1);
   endfunction

   // entered and left on a falling edge
   task automatic load(input batch_t v);
      for (int i = 0; i < N; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = v[i];
         chk("in_ready_load", 32'(bus.in_ready), 32'd1);
         chk("busy_load", 32'(busy), 32'd0);
         @(negedge clk);
      end
   endtask

   task automatic run(input batch_t v, input int bp_idx);
      logic [W-1:0] q[$];
      int exp_cyc, sc, w, idx, held;
      logic pv, pl;
      logic [W-1:0] pd;
      foreach (v[i]) q.push_back(v[i]);
      q.rsort();
      exp_cyc = model_cycles(v);
      load(v);
      sc = 0;
      w  = 0;
      while (!bus.out_valid && w < 200) begin
         chk("in_ready_sort", 32'(bus.in_ready), 32'd0);
         chk("busy_sort", 32'(busy), 32'd1);
         bus.in_valid  = 1'($urandom);
         bus.in_data   = W'($urandom);
         bus.out_ready = 1'b0;
         sc++;
         w++;
         @(negedge clk);
      end
      if (!bus.out_valid) chk("sort_timeout", 32'd0, 32'd1);
      chk("sort_len", 32'(sc), 32'(exp_cyc));
      chk("sort_cycles", 32'(sort_cycles), 32'(exp_cyc));
      idx  = 0;
      held = 0;
      pv   = 1'b0;
      pd   = '0;
      pl   = 1'b0;
      w    = 0;
      while (idx < N && w < 300) begin
         chk("out_valid", 32'(bus.out_valid), 32'd1);
         chk("in_ready_drain", 32'(bus.in_ready), 32'd0);
         if (pv) begin
            chk("hold_data", 32'(bus.out_data), 32'(pd));
            chk("hold_last", 32'(bus.out_last), 32'(pl));
         end
         chk("out_data", 32'(bus.out_data), 32'(q[idx]));
         chk("out_last", 32'(bus.out_last), 32'(idx == N - 1));
         if (idx == bp_idx && held < 3) begin
            bus.out_ready = 1'b0;
            held++;
         end else if (bp_idx >= 0) begin
            bus.out_ready = 1'b1;
         end else begin
            bus.out_ready = ($urandom_range(0, 2) != 0);
         end
         pv = !bus.out_ready;
         pd = bus.out_data;
         pl = bus.out_last;
         if (bus.out_ready) idx++;
         bus.in_valid = 1'($urandom);
         bus.in_data  = W'($urandom);
         w++;
         @(negedge clk);
      end
      if (idx < N) chk("drain_timeout", 32'(idx), 32'(N));
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chk("in_ready_after", 32'(bus.in_ready), 32'd1);
      chk("out_valid_after", 32'(bus.out_valid), 32'd0);
      chk("busy_after", 32'(busy), 32'd0);
      chk("sort_cycles_hold", 32'(sort_cycles), 32'(exp_cyc));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
      chk({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_sort_cycles"}, 32'(sort_cycles), 32'd0);
   endtask

   initial begin
      batch_t b;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      #1;
      chk_reset_vals("rst");
      @(negedge clk);
      @(negedge clk);
      chk_reset_vals("rst_hold");
      rst = 1'b0;

      b = '{8'h08, 8'h10, 8'h13, 8'h45, 8'h01};
      run(b, -1);
      chk("plan_mixed", 32'(sort_cycles), 32'd16);
      b = '{8'h45, 8'h13, 8'h10, 8'h08, 8'h01};
      run(b, -1);
      chk("plan_sorted", 32'(sort_cycles), 32'd4);
      b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      run(b, -1);
      chk("plan_worst", 32'(sort_cycles), 32'(worst_cycles(N)));
      b = '{8'h07, 8'h07, 8'h03, 8'h07, 8'h03};
      run(b, 1);

      b = '{8'h08, 8'h10, 8'h13, 8'h45, 8'h01};
      load(b);
      @(negedge clk);
      @(negedge clk);
      chk("mid_sort_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk_reset_vals("abort");
      @(negedge clk);
      rst = 1'b0;
      chk_reset_vals("abort_rel");
      b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      run(b, -1);

      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < N; i++)
            b[i] = (k < 4) ? W'($urandom_range(0, 7)) : W'($urandom);
         run(b, (k % 3 == 0) ? int'($urandom_range(0, N - 1)) : -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/bubble_sort_stream.md
Name: bubble_sort_stream

Overview:
Streaming wrapper around the team's adjacent-swap sorter.
- Accepts N unsorted words over a valid/ready input.
- Sorts them in place into descending order, one compare/swap per clock.
- Streams the sorted words out, largest first, over a valid/ready output.
- Provides the write and read ends around the sort array. The array is no longer preset by reset; software and test logic fill and drain it through the handshakes.

Parameters:
- N, 5, number of elements per batch (N >= 2).
- W, 8, element width in bits.
- CW, 8, width of sort-cycle counter (must hold N*(N-1)).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input word.
- in_data  in  W  input word (unsigned).
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts output word.
- out_data  out  W  sorted output word.
- out_last  out  1  marks the final (N-th, smallest) output word.
- busy  out  1  high in SORT or DRAIN.
- sort_cycles  out  CW  clock count spent in SORT for the current/last batch.

Behaviour:
- Reset (async, rst=1):
  - State goes to LOAD; all array entries, indices, swap flag and sort_cycles are cleared to 0.
  - Output values during and after reset: in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
- States: LOAD -> SORT -> DRAIN -> LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready, in_data is written to r[wr_idx] and wr_idx increments.
  - The handshake at wr_idx==N-1 moves to SORT next cycle, with wr_idx=0, p=0, swapped=0, sort_cycles=0.
- SORT:
  - in_ready=0; in_valid is ignored.
  - Each cycle compares r[p] with r[p+1] (unsigned). If r[p]<r[p+1] they swap and swapped is set. Equal values never swap.
  - sort_cycles increments every SORT cycle.
  - p runs 0..N-2; one pass = N-1 cycles.
  - At p==N-2: if no swap occurred anywhere in this pass, including this cycle, go to DRAIN; otherwise p=0, swapped=0, start a new pass.
  - An already-sorted batch takes exactly N-1 SORT cycles. A strictly ascending batch takes N*(N-1) cycles.
- DRAIN:
  - out_valid=1, out_data=r[rd_idx] (registered array read, no extra latency), out_last=(rd_idx==N-1).
  - Backpressure: while out_valid && !out_ready, out_data and out_last hold stable.
  - On handshake rd_idx increments. The handshake with out_last=1 returns to LOAD next cycle with rd_idx=0.
  - sort_cycles holds its value through DRAIN and LOAD until the next SORT entry.
- busy = (state != LOAD).
- No input word is accepted in the cycle the last output word handshakes; LOAD begins the following cycle.
- Reset asserted mid-SORT or mid-DRAIN aborts the batch. The partial data is discarded and nothing further is emitted.

Decomposition:
- Package bubble_sort_pkg holds:
  - state enum (LOAD, SORT, DRAIN);
  - function for worst-case sort cycles N*(N-1);
  - clog2-based index width constant.
- One natural sub-module, sort_cmp_swap: combinational compare of two W-bit words, returning the swapped pair and a swap flag. Instantiate it once, muxed by p.
- FSM, indices and array stay in the top.

Test Plan:
- Load 08,10,13,45,01 -> outputs 45,13,10,08,01 with out_last on 01 only; sort_cycles=16.
- Load already-sorted 45,13,10,08,01 -> SORT lasts exactly 4 cycles (sort_cycles=4); identical output order.
- Load 01,02,03,04,05 -> sort_cycles=20; outputs 05,04,03,02,01.
- Duplicates 07,07,03,07,03 -> outputs 07,07,07,03,03. Hold out_ready=0 for 3 cycles on the second word -> out_data stays 07 and out_valid stays 1.
- in_valid toggling during SORT/DRAIN -> in_ready=0, array unaffected. Back-to-back batches: second batch is accepted starting the cycle after the first batch's out_last handshake.
- Assert rst mid-SORT of 08,10,13,45,01 -> next cycle in LOAD, out_valid=0, sort_cycles=0. A fresh batch 01,02,03,04,05 then sorts correctly.
